pc_fetch_unit: RTL and testbench

- Sequential consumer of the next-PC datapath. Holds the program counter, issues instruction-memory read requests, buffers returned words, and presents `{instr, pc}` to decode over a valid/ready handshake.
- Takes the branch/jump redirect (taken-branch AND output plus target-adder result) and flushes in-flight work.
- Sits between the next-PC mux/adder logic and the decode stage.

---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction-memory requests and the fetch
// buffer feeding decode, with branch/jump redirect and in-flight flush.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr      request channel (word aligned)
//   imem_rsp_valid, imem_rdata           in-order read responses
//   redirect_valid, redirect_pc          taken branch/jump target
//   instr_valid/ready, instr, instr_pc   decode handshake
//   misalign_err        one-cycle pulse after a misaligned redirect target
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

    // Free-running state
    logic          run_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          misalign_q;

    // PCs of requests still waiting for their response
    logic [31:0]   pcq_q [BUF_DEPTH];
    logic [PW-1:0] pcq_wr_q, pcq_rd_q;

    // Instruction buffer
    logic [31:0]   ib_instr_q [BUF_DEPTH];
    logic [31:0]   ib_pc_q [BUF_DEPTH];
    logic [PW-1:0] ib_wr_q, ib_rd_q;

    logic          req_hs;
    logic          rsp_acc;
    logic          rsp_keep;
    logic          pop;
    logic [CW:0]   used;

    assign instr_valid  = (occ_q != '0);
    assign instr        = ib_instr_q[ib_rd_q];
    assign instr_pc     = ib_pc_q[ib_rd_q];
    assign misalign_err = misalign_q;
    assign imem_addr    = fetch_pc_q;

    assign pop = instr_valid & instr_ready;

    // A slot popped this cycle is free for a new request, which lets the
    // buffer stream one word per cycle. The sum can only shrink while a
    // request waits, so valid never falls before its handshake.
    assign used = {1'b0, out_q} + {1'b0, occ_q} - (CW + 1)'(pop);

    // run_q holds requests off until the first edge after reset release.
    assign imem_req_valid = run_q & ~redirect_valid & (used < DEPTH_C);

    assign req_hs = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is stray and ignored.
    assign rsp_acc  = imem_rsp_valid & (out_q != '0);
    assign rsp_keep = rsp_acc & (drop_q == '0) & ~redirect_valid;

    always_comb begin
        out_d = out_q + CW'(req_hs) - CW'(rsp_acc);

        if (redirect_valid) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CW'(rsp_keep) - CW'(pop);
        end

        // Everything still in flight after a redirect belongs to the old
        // path; counting from out_d makes back-to-back redirects add up.
        if (redirect_valid) begin
            drop_d = out_d;
        end else if (rsp_acc && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end else begin
            drop_d = drop_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            misalign_q <= 1'b0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pcq_q[i]      <= '0;
                ib_instr_q[i] <= '0;
                ib_pc_q[i]    <= '0;
            end
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);

            if (req_hs) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
            end
            if (rsp_keep) begin
                ib_instr_q[ib_wr_q] <= imem_rdata;
                ib_pc_q[ib_wr_q]    <= pcq_q[pcq_rd_q];
            end

            if (redirect_valid) begin
                pcq_wr_q <= '0;
                pcq_rd_q <= '0;
                ib_wr_q  <= '0;
                ib_rd_q  <= '0;
            end else begin
                if (req_hs) begin
                    pcq_wr_q <= pcq_wr_q + PW'(1);
                end
                if (rsp_keep) begin
                    pcq_rd_q <= pcq_rd_q + PW'(1);
                    ib_wr_q  <= ib_wr_q + PW'(1);
                end
                if (pop) begin
                    ib_rd_q <= ib_rd_q + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed tests for pc_fetch_unit with a fixed-latency
// in-order memory model; data word for address a is a ^ KEY.
module tb_pc_fetch_unit;

    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;

    logic        mem_v = 1'b0;
    logic [31:0] mem_d = 32'h0;
    logic        inj_v = 1'b0;
    logic [31:0] inj_d = 32'h0;

    assign imem_rsp_valid = mem_v | inj_v;
    assign imem_rdata     = inj_v ? inj_d : mem_d;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int mem_lat = 1;
    int mcyc    = 0;

    logic        hs_n   = 1'b0;
    logic [31:0] addr_n = 32'h0;
    logic [31:0] pend_a[$];
    int          pend_t[$];

    logic [31:0] req_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] ins_log[$];
    int          dcy_log[$];

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic int qi(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Memory: sample the request handshake mid-cycle, answer mem_lat
    // cycles after the handshake cycle.
    always @(negedge clk) begin
        hs_n   = imem_req_valid & imem_req_ready;
        addr_n = imem_addr;
    end

    always begin
        @(posedge clk);
        if (!rst_n) begin
            pend_a.delete();
            pend_t.delete();
        end else if (hs_n) begin
            pend_a.push_back(addr_n);
            pend_t.push_back(mcyc + mem_lat);
        end
        mcyc++;
        #1;
        if (pend_t.size() > 0 && pend_t[0] == mcyc) begin
            mem_v = 1'b1;
            mem_d = word_of(pend_a[0]);
            void'(pend_a.pop_front());
            void'(pend_t.pop_front());
        end else begin
            mem_v = 1'b0;
        end
    end

    // Each call spans n cycles: record at negedge, advance to posedge+1.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_addr);
            if (instr_valid && instr_ready) begin
                pc_log.push_back(instr_pc);
                ins_log.push_back(instr);
                dcy_log.push_back(cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        pc_log.delete();
        ins_log.delete();
        dcy_log.delete();
    endtask

    task automatic do_reset(input int lat);
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inj_v          = 1'b0;
        mem_lat        = lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        #2;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid);
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL reset_misalign: got %b want 0", misalign_err);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", imem_addr);
        end
        checks++;
        if (instr !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h want 0", instr);
        end
        checks++;
        if (instr_pc !== 32'h0) begin
            errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc);
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1);
        run(12);
        checks++;
        if (req_log.size() != 12) begin
            errors++; $display("FAIL stream_req_count: got %0d want 12", req_log.size());
        end
        for (int i = 0; i < 12; i++) begin
            e = 32'(i) << 2;
            checks++;
            if (qa(req_log, i) !== e) begin
                errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, qa(req_log, i), e);
            end
        end
        checks++;
        if (pc_log.size() != 10) begin
            errors++; $display("FAIL stream_deliver_count: got %0d want 10", pc_log.size());
        end
        for (int i = 0; i < 10; i++) begin
            e = 32'(i) << 2;
            checks++;
            if (qa(pc_log, i) !== e) begin
                errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, qa(pc_log, i), e);
            end
            checks++;
            if (qa(ins_log, i) !== word_of(e)) begin
                errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, qa(ins_log, i), word_of(e));
            end
            checks++;
            if (qi(dcy_log, i) != i + 2) begin
                errors++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, qi(dcy_log, i), i + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        instr_ready = 1'b0;
        run(6);
        checks++;
        if (req_log.size() != 2) begin
            errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size());
        end
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_req_stalled: got %b want 0", imem_req_valid);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
            errors++; $display("FAIL bp_head: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", instr_valid, instr_pc, instr, word_of(32'h0));
        end
        @(posedge clk);
        #1;
        cyc++;
        instr_ready = 1'b1;
        run(6);
        checks++;
        if (qa(pc_log, 0) !== 32'h0 || qa(pc_log, 1) !== 32'h4 || qa(pc_log, 2) !== 32'h8) begin
            errors++; $display("FAIL bp_order: got %h %h %h want 0 4 8", qa(pc_log, 0), qa(pc_log, 1), qa(pc_log, 2));
        end
        checks++;
        if (qa(req_log, 2) !== 32'h8) begin
            errors++; $display("FAIL bp_resume_addr: got %h want 8", qa(req_log, 2));
        end
        checks++;
        if (qi(dcy_log, 0) != 7) begin
            errors++; $display("FAIL bp_release_cycle: got %0d want 7", qi(dcy_log, 0));
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(3);
        run(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        run(1);
        redirect_valid = 1'b0;
        run(10);
        checks++;
        if (qa(req_log, 2) !== 32'h100 || qa(req_log, 3) !== 32'h104) begin
            errors++; $display("FAIL rd_addr: got %h %h want 100 104", qa(req_log, 2), qa(req_log, 3));
        end
        checks++;
        if (qa(pc_log, 0) !== 32'h100 || qa(ins_log, 0) !== word_of(32'h100)) begin
            errors++; $display("FAIL rd_first: got pc=%h i=%h want pc=100 i=%h", qa(pc_log, 0), qa(ins_log, 0), word_of(32'h100));
        end
        checks++;
        if (qi(dcy_log, 0) != 8) begin
            errors++; $display("FAIL rd_first_cycle: got %0d want 8", qi(dcy_log, 0));
        end
    endtask

    task automatic test_misalign();
        do_reset(1);
        run(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL ma_req_forced: got %b want 0", imem_req_valid);
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL ma_early: got %b want 0", misalign_err);
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        clear_logs();
        @(negedge clk);
        checks++;
        if (misalign_err !== 1'b1) begin
            errors++; $display("FAIL ma_pulse: got %b want 1", misalign_err);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL ma_new_req: got v=%b a=%h want v=1 a=100", imem_req_valid, imem_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++; $display("FAIL ma_pulse_end: got %b want 0", misalign_err);
        end
        @(posedge clk);
        #1;
        cyc++;
        run(4);
        checks++;
        if (qa(pc_log, 0) !== 32'h100 || qa(pc_log, 1) !== 32'h104) begin
            errors++; $display("FAIL ma_pcs: got %h %h want 100 104", qa(pc_log, 0), qa(pc_log, 1));
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        run(1);
        redirect_valid = 1'b0;
        run(8);
        checks++;
        if (qa(req_log, 0) !== 32'hFFFF_FFF8 || qa(req_log, 1) !== 32'hFFFF_FFFC || qa(req_log, 2) !== 32'h0) begin
            errors++; $display("FAIL wrap_addr: got %h %h %h want fffffff8 fffffffc 0", qa(req_log, 0), qa(req_log, 1), qa(req_log, 2));
        end
        checks++;
        if (qa(pc_log, 0) !== 32'hFFFF_FFF8 || qa(pc_log, 1) !== 32'hFFFF_FFFC || qa(pc_log, 2) !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got %h %h %h want fffffff8 fffffffc 0", qa(pc_log, 0), qa(pc_log, 1), qa(pc_log, 2));
        end
        checks++;
        if (qa(ins_log, 2) !== word_of(32'h0)) begin
            errors++; $display("FAIL wrap_instr: got %h want %h", qa(ins_log, 2), word_of(32'h0));
        end
    endtask

    task automatic test_back_to_back();
        bit saw_200;
        do_reset(3);
        run(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        run(1);
        redirect_pc    = 32'h0000_0300;
        run(1);
        redirect_valid = 1'b0;
        run(10);
        checks++;
        if (qa(req_log, 2) !== 32'h300) begin
            errors++; $display("FAIL b2b_addr: got %h want 300", qa(req_log, 2));
        end
        checks++;
        if (qa(pc_log, 0) !== 32'h300 || qa(ins_log, 0) !== word_of(32'h300)) begin
            errors++; $display("FAIL b2b_first: got pc=%h i=%h want pc=300 i=%h", qa(pc_log, 0), qa(ins_log, 0), word_of(32'h300));
        end
        saw_200 = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 32'h200) saw_200 = 1'b1;
        checks++;
        if (saw_200 !== 1'b0) begin
            errors++; $display("FAIL b2b_stale_target: got request to 200 want none");
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        run(4);
        imem_req_ready = 1'b0;
        run(1);
        instr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL rm_hold_req: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_addr);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin
            errors++; $display("FAIL rm_hold_buf: got v=%b pc=%h want v=1 pc=c", instr_valid, instr_pc);
        end
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL rm_stable: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rm_async: got req=%b iv=%b want 0 0", imem_req_valid, instr_valid);
        end
        checks++;
        if (imem_addr !== 32'h0 || instr_pc !== 32'h0 || instr !== 32'h0) begin
            errors++; $display("FAIL rm_values: got a=%h pc=%h i=%h want 0 0 0", imem_addr, instr_pc, instr);
        end
        do_reset(1);
        inj_v = 1'b1;
        inj_d = 32'hBAD0_BAD0;
        run(1);
        inj_v = 1'b0;
        run(4);
        checks++;
        if (qa(req_log, 0) !== 32'h0) begin
            errors++; $display("FAIL rm_first_addr: got %h want 0", qa(req_log, 0));
        end
        checks++;
        if (qa(pc_log, 0) !== 32'h0 || qa(ins_log, 0) !== word_of(32'h0) || qi(dcy_log, 0) != 2) begin
            errors++; $display("FAIL rm_stray_rsp: got pc=%h i=%h c=%0d want pc=0 i=%h c=2", qa(pc_log, 0), qa(ins_log, 0), qi(dcy_log, 0), word_of(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
